// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller slice.
//   state_t  : controller FSM states (RUN, MEM_WAIT, ERR)
//   REG_ZERO : architectural x0 index, never a real dependency
//   ctrl_t   : bundle of pipeline stall/flush controls
//   ctrl_freeze / ctrl_run : canonical control patterns
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } ctrl_t;

  // Whole front of the pipe holds while MEM is stuck; MEM/WB gets a bubble
  // so the stalled access does not write the register file repeatedly.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c = '0;
    c.pc_stall     = 1'b1;
    c.if_id_stall  = 1'b1;
    c.id_ex_stall  = 1'b1;
    c.ex_mem_stall = 1'b1;
    c.mem_wb_flush = 1'b1;
    return c;
  endfunction

  // Normal-flow controls when memory is not holding: redirect beats load-use,
  // since the dependent instruction in ID is squashed anyway.
  function automatic ctrl_t ctrl_run(input logic redirect, input logic lu_hit);
    ctrl_t c;
    c = '0;
    if (redirect) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (lu_hit) begin
      c.pc_stall    = 1'b1;
      c.if_id_stall = 1'b1;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use hazard compare: flags when the load in EX writes a register the
// instruction in ID actually reads. x0 is never a dependency.
//   id_rs1/id_rs2, id_rs1_used/id_rs2_used : ID source operands
//   id_ex_rd, id_ex_mem_re                 : EX destination, EX is a load
//   lu_hit                                 : one-cycle stall required
module hazard_lu_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_re,
  output logic       lu_hit
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_rs1_used && (id_rs1 == id_ex_rd);
  assign rs2_match = id_rs2_used && (id_rs2 == id_ex_rd);
  assign lu_hit    = id_ex_mem_re && (id_ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage core. Resolves what
// forwarding cannot: load-use, data-memory wait and EX redirect.
//   clk, rst_n         : clock, async active-low reset
//   id_*/id_ex_*       : operand/destination info for load-use detection
//   ex_redirect        : taken branch/jump resolved in EX
//   mem_req, mem_ack   : data-memory handshake of the instruction in MEM
//   *_stall / *_flush  : per-stage pipeline controls (combinational)
//   mem_timeout_err    : sticky, memory never acknowledged
//   stall_cnt          : saturating count of cycles with pc_stall=1
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_re,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              lu_hit;
  logic              mem_hold;
  ctrl_t             ctrl;

  hazard_lu_detect u_lu_detect (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_ex_rd     (id_ex_rd),
    .id_ex_mem_re (id_ex_mem_re),
    .lu_hit       (lu_hit)
  );

  // A dropped request counts as completion, so only req&~ack holds.
  assign mem_hold = mem_req && !mem_ack;

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_hold) begin
          ctrl    = ctrl_freeze();
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          ctrl = ctrl_run(ex_redirect, lu_hit);
        end
      end
      ST_MEM_WAIT: begin
        // Redirect/load-use stay asserted by the held stages and are only
        // acted on once the access completes.
        if (!mem_hold) begin
          ctrl    = ctrl_run(ex_redirect, lu_hit);
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          ctrl    = ctrl_freeze();
          state_d = ST_ERR;
        end else begin
          ctrl   = ctrl_freeze();
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        ctrl = ctrl_freeze();
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (pc_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Controls are masked while reset is held so an in-flight request cannot
  // freeze the pipe before the state register has been released.
  assign pc_stall        = rst_n && ctrl.pc_stall;
  assign if_id_stall     = rst_n && ctrl.if_id_stall;
  assign if_id_flush     = rst_n && ctrl.if_id_flush;
  assign id_ex_stall     = rst_n && ctrl.id_ex_stall;
  assign id_ex_flush     = rst_n && ctrl.id_ex_flush;
  assign ex_mem_stall    = rst_n && ctrl.ex_mem_stall;
  assign mem_wb_flush    = rst_n && ctrl.mem_wb_flush;
  assign mem_timeout_err = (state_q == ST_ERR);
  assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=3 so
// counter saturation is reachable).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_rs1_used, id_rs2_used, id_ex_mem_re;
  logic       ex_redirect, mem_req, mem_ack;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, mem_wb_flush, mem_timeout_err;
  logic [2:0] stall_cnt;
  logic [6:0] outs;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_LU     = 7'b1100100;
  localparam logic [6:0] O_REDIR  = 7'b0010100;
  localparam logic [6:0] O_FREEZE = 7'b1101011;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_ex_rd        (id_ex_rd),
    .id_ex_mem_re    (id_ex_mem_re),
    .ex_redirect     (ex_redirect),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_flush    (mem_wb_flush),
    .mem_timeout_err (mem_timeout_err),
    .stall_cnt       (stall_cnt)
  );

  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                 id_ex_flush, ex_mem_stall, mem_wb_flush};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_ex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_ex_mem_re = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #3;
    check("reset_outs", 32'(outs), 32'(O_NONE));
    check("reset_cnt", 32'(stall_cnt), 0);
    check("reset_err", 32'(mem_timeout_err), 0);
    #9 rst_n = 1'b1;

    // 1: load-use, one cycle only
    step();
    id_ex_mem_re = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1 check("lu_hit", 32'(outs), 32'(O_LU));
    step();
    id_ex_mem_re = 1'b0;
    #1 check("lu_next", 32'(outs), 32'(O_NONE));
    check("lu_cnt", 32'(stall_cnt), 1);

    // 2: x0 and unused operand
    id_ex_mem_re = 1'b1; id_ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #1 check("lu_x0", 32'(outs), 32'(O_NONE));
    id_ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_rs2_used = 1'b0;
    #1 check("lu_rs2_unused", 32'(outs), 32'(O_NONE));
    id_rs2_used = 1'b1;
    #1 check("lu_rs2_used", 32'(outs), 32'(O_LU));
    step();
    clear_inputs();
    #1 check("lu_rs2_cnt", 32'(stall_cnt), 2);

    // 3: redirect wins over load-use
    pulse_reset();
    check("rst_cnt3", 32'(stall_cnt), 0);
    step();
    ex_redirect = 1'b1;
    id_ex_mem_re = 1'b1; id_ex_rd = 5'd9; id_rs2 = 5'd9; id_rs2_used = 1'b1;
    #1 check("redir_lu", 32'(outs), 32'(O_REDIR));
    step();
    clear_inputs();
    #1 check("redir_cnt", 32'(stall_cnt), 0);

    // 4: memory wait, ack on 4th cycle
    mem_req = 1'b1;
    #1 check("mw_c0", 32'(outs), 32'(O_FREEZE));
    step();
    #1 check("mw_c1", 32'(outs), 32'(O_FREEZE));
    step();
    #1 check("mw_c2", 32'(outs), 32'(O_FREEZE));
    step();
    mem_ack = 1'b1;
    #1 check("mw_ack", 32'(outs), 32'(O_NONE));
    step();
    clear_inputs();
    #1 check("mw_cnt", 32'(stall_cnt), 3);
    check("mw_err", 32'(mem_timeout_err), 0);
    // Back in RUN: a fresh hold freezes again, load-use is honoured.
    id_ex_mem_re = 1'b1; id_ex_rd = 5'd4; id_rs1 = 5'd4; id_rs1_used = 1'b1;
    #1 check("mw_run_lu", 32'(outs), 32'(O_LU));
    clear_inputs();

    // 5: timeout -> ERR after 5 frozen cycles, counter saturates at 7
    pulse_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("to_frz%0d", i), 32'(outs), 32'(O_FREEZE));
      check($sformatf("to_noerr%0d", i), 32'(mem_timeout_err), 0);
      step();
    end
    check("to_err", 32'(mem_timeout_err), 1);
    check("to_cnt5", 32'(stall_cnt), 5);
    mem_req = 1'b0;
    #1 check("to_sticky_outs", 32'(outs), 32'(O_FREEZE));
    step();
    step();
    check("to_cnt7", 32'(stall_cnt), 7);
    step();
    check("to_sat", 32'(stall_cnt), 7);
    check("to_sticky_err", 32'(mem_timeout_err), 1);
    rst_n = 1'b0;
    #1 check("to_rst_outs", 32'(outs), 32'(O_NONE));
    check("to_rst_err", 32'(mem_timeout_err), 0);
    check("to_rst_cnt", 32'(stall_cnt), 0);
    rst_n = 1'b1;
    #1 check("to_run_outs", 32'(outs), 32'(O_NONE));

    // 6: async reset mid-wait, then redirect held through a wait
    step();
    mem_req = 1'b1;
    step();
    step();
    check("ar_cnt_pre", 32'(stall_cnt), 2);
    rst_n = 1'b0;
    #1 check("ar_outs", 32'(outs), 32'(O_NONE));
    check("ar_cnt", 32'(stall_cnt), 0);
    rst_n = 1'b1;
    ex_redirect = 1'b1;
    #1 check("ar_masked", 32'(outs), 32'(O_FREEZE));
    step();
    #1 check("ar_wait_masked", 32'(outs), 32'(O_FREEZE));
    mem_ack = 1'b1;
    #1 check("ar_ack_redir", 32'(outs), 32'(O_REDIR));
    step();
    clear_inputs();
    #1 check("ar_final_outs", 32'(outs), 32'(O_NONE));
    check("ar_final_cnt", 32'(stall_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
